pipelined_cla_adder: RTL



---
 rtl/pcla_pkg.sv | 28 ++
 rtl/cla_group.sv | 53 +++++
 rtl/pipelined_cla_adder.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/pcla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder: default sizes,
// segment/group derivation helpers and a stage record for benches.
package pcla_pkg;

  localparam int PCLA_WIDTH  = 32;
  localparam int PCLA_STAGES = 2;
  localparam int PCLA_BLOCK  = 4;

  // Bits resolved by one pipeline stage.
  function automatic int seg_w(input int width, input int stages);
    return width / stages;
  endfunction

  // Number of lookahead groups inside one segment.
  function automatic int n_groups(input int seg, input int block);
    return seg / block;
  endfunction

  // Snapshot of one pipeline stage at the default width.
  typedef struct packed {
    logic                  valid;
    logic                  carry;
    logic [PCLA_WIDTH-1:0] low_sum;
    logic [PCLA_WIDTH-1:0] a_hi;
    logic [PCLA_WIDTH-1:0] b_hi;
  } pcla_stage_t;

endpackage

// File: rtl/cla_group.sv
// One lookahead group of BLOCK bits: local carries, sum bits and the
// group generate/propagate pair consumed by the second-level lookahead.
module cla_group
  import pcla_pkg::*;
#(
  parameter int BLOCK = PCLA_BLOCK
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             c_in,
  output logic [BLOCK-1:0] s,
  output logic             grp_g,
  output logic             grp_p,
  output logic             c_out
);

  logic [BLOCK-1:0] g;
  logic [BLOCK-1:0] p;
  logic [BLOCK:0]   c;

  // Flattened lookahead: every carry is a sum of products of g/p and c_in.
  always_comb begin
    logic acc;
    logic term;
    acc  = 1'b0;
    term = 1'b0;
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    for (int i = 0; i <= BLOCK; i++) begin
      term = c_in;
      for (int j = 0; j < i; j++) term = term & p[j];
      acc = term;
      for (int j = 0; j < i; j++) begin
        term = g[j];
        for (int m = j + 1; m < i; m++) term = term & p[m];
        acc = acc | term;
      end
      c[i] = acc;
    end
    acc = 1'b0;
    for (int j = 0; j < BLOCK; j++) begin
      term = g[j];
      for (int m = j + 1; m < BLOCK; m++) term = term & p[m];
      acc = acc | term;
    end
    grp_g = acc;
    grp_p = &p;
    s     = p ^ c[BLOCK-1:0];
    c_out = c[BLOCK];
  end

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready handshake.
// Each stage resolves one SEG-bit segment and registers it together with
// the segment carry-out; the final stage registers drive s/cout directly.
// Optional macro PCLA_FLAGS_EN adds registered zero and signed-overflow flags.
module pipelined_cla_adder
  import pcla_pkg::*;
#(
  parameter int WIDTH  = PCLA_WIDTH,
  parameter int STAGES = PCLA_STAGES,
  parameter int BLOCK  = PCLA_BLOCK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef PCLA_FLAGS_EN
  output logic             zero,
  output logic             ovf,
`endif
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  localparam int SEG = seg_w(WIDTH, STAGES);
  localparam int NG  = n_groups(SEG, BLOCK);

  if ((WIDTH % STAGES) != 0 || (SEG % BLOCK) != 0) begin : g_bad_cfg
    $error("pipelined_cla_adder: WIDTH must split into STAGES segments of whole BLOCK groups");
  end

  // Registered stage contents, gathered for the ready chain and outputs.
  logic [STAGES-1:0]            stg_vld;
  logic [STAGES-1:0]            stg_co;
  logic [STAGES-1:0][WIDTH-1:0] stg_sum;
  logic [STAGES-1:0][WIDTH-1:0] stg_a;
  logic [STAGES-1:0][WIDTH-1:0] stg_b;

  // What each stage sees at its input.
  logic [STAGES-1:0]            vin;
  logic [STAGES-1:0]            cin_s;
  logic [STAGES-1:0][WIDTH-1:0] ain;
  logic [STAGES-1:0][WIDTH-1:0] bin;
  logic [STAGES-1:0][WIDTH-1:0] lin;

  logic [STAGES:0] rdy;

  // Ready chain from the consumer back to the input; empty stages always accept.
  always_comb begin
    rdy         = '0;
    rdy[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) rdy[k] = !stg_vld[k] || rdy[k+1];
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             vld_d, vld_q;
    logic             co_d, co_q;
    logic [WIDTH-1:0] sum_d, sum_q;
    logic [WIDTH-1:0] a_d, a_q;
    logic [WIDTH-1:0] b_d, b_q;
    logic             load;
    logic [SEG-1:0]   seg_a, seg_b, seg_s;
    logic             seg_co;
    logic [NG-1:0]    grp_g, grp_p, grp_co, grp_ci;
    logic [WIDTH-1:0] full_sum;

    if (k == 0) begin : g_in_prep
      assign vin[k]   = in_valid;
      assign ain[k]   = a;
      assign bin[k]   = sub ? ~b : b;
      assign cin_s[k] = sub | cin;
      assign lin[k]   = '0;
    end else begin : g_in_pipe
      assign vin[k]   = stg_vld[k-1];
      assign ain[k]   = stg_a[k-1];
      assign bin[k]   = stg_b[k-1];
      assign cin_s[k] = stg_co[k-1];
      assign lin[k]   = stg_sum[k-1];
    end

    assign seg_a = ain[k][k*SEG +: SEG];
    assign seg_b = bin[k][k*SEG +: SEG];

    for (genvar j = 0; j < NG; j++) begin : g_grp
      cla_group #(.BLOCK(BLOCK)) u_grp (
        .a     (seg_a[j*BLOCK +: BLOCK]),
        .b     (seg_b[j*BLOCK +: BLOCK]),
        .c_in  (grp_ci[j]),
        .s     (seg_s[j*BLOCK +: BLOCK]),
        .grp_g (grp_g[j]),
        .grp_p (grp_p[j]),
        .c_out (grp_co[j])
      );
    end

    // Second-level lookahead: carry into each group from group G/P and segment carry-in.
    always_comb begin
      logic acc;
      logic term;
      acc    = 1'b0;
      term   = 1'b0;
      grp_ci = '0;
      for (int i = 0; i < NG; i++) begin
        term = cin_s[k];
        for (int j = 0; j < i; j++) term = term & grp_p[j];
        acc = term;
        for (int j = 0; j < i; j++) begin
          term = grp_g[j];
          for (int m = j + 1; m < i; m++) term = term & grp_p[m];
          acc = acc | term;
        end
        grp_ci[i] = acc;
      end
    end

    assign seg_co = grp_co[NG-1];

    // Next-state: load on a transfer, otherwise hold (keeps stalled outputs stable).
    always_comb begin
      load     = rdy[k] & vin[k];
      vld_d    = rdy[k] ? vin[k] : vld_q;
      full_sum = lin[k];
      full_sum[k*SEG +: SEG] = seg_s;
      co_d     = co_q;
      sum_d    = sum_q;
      a_d      = a_q;
      b_d      = b_q;
      if (load) begin
        co_d  = seg_co;
        sum_d = full_sum;
        a_d   = ain[k];
        b_d   = bin[k];
      end
    end

    // Stage register; reset clears data as well so nothing undefined leaks out.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        co_q  <= 1'b0;
        sum_q <= '0;
        a_q   <= '0;
        b_q   <= '0;
      end else begin
        vld_q <= vld_d;
        co_q  <= co_d;
        sum_q <= sum_d;
        a_q   <= a_d;
        b_q   <= b_d;
      end
    end

    assign stg_vld[k] = vld_q;
    assign stg_co[k]  = co_q;
    assign stg_sum[k] = sum_q;
    assign stg_a[k]   = a_q;
    assign stg_b[k]   = b_q;

`ifdef PCLA_FLAGS_EN
    if (k == STAGES - 1) begin : g_flags
      logic zero_d, zero_q;
      logic ovf_d, ovf_q;
      logic c_msb;

      // Flags follow the final sum: carry into MSB recovered as s ^ a ^ b.
      always_comb begin
        c_msb  = seg_s[SEG-1] ^ seg_a[SEG-1] ^ seg_b[SEG-1];
        zero_d = zero_q;
        ovf_d  = ovf_q;
        if (load) begin
          zero_d = (full_sum == '0);
          ovf_d  = c_msb ^ seg_co;
        end
      end

      // Flag registers travel with the final-stage sum.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          zero_q <= 1'b0;
          ovf_q  <= 1'b0;
        end else begin
          zero_q <= zero_d;
          ovf_q  <= ovf_d;
        end
      end

      assign zero = zero_q;
      assign ovf  = ovf_q;
    end
`endif
  end

  assign in_ready  = rdy[0];
  assign out_valid = stg_vld[STAGES-1];
  assign s         = stg_sum[STAGES-1];
  assign cout      = stg_co[STAGES-1];

endmodule
